enemy_tally: RTL

- Counts how many enemy planes are still alive by scanning a per-plane alive mask, one bit per clock.
- Produces the live plane count, an all-clear flag and a mask-shape check.
- Sits between the enemy sprite/collision logic, which drives the alive bits, and the game-control FSM.
- Its count is the inverse of the count-to-visibility-mask mapping: it decodes a visibility-style mask back into a plane amount.

---
 rtl/enemy_tally.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/enemy_tally.sv
// -----------------------------------------------------------------------------
// enemy_tally
//
// Counts the enemy planes still alive by scanning a snapshot of the per-plane
// alive mask, one bit per clock. It decodes a visibility-style (thermometer)
// mask back into a plane amount. It also reports whether the mask really was a
// thermometer code, meaning every alive bit is contiguous from bit 0.
//
// Ports
//   clk        in   1         system clock, rising edge
//   resetn     in   1         synchronous active-low reset
//   alive      in   N_PLANES  bit i = 1 -> enemy slot i alive
//   start      in   1         tally request, only honoured in IDLE
//   busy       out  1         high while scanning
//   done       out  1         one-cycle pulse when a result is published
//   count      out  CNT_W     number of ones in the snapshot
//   all_clear  out  1         count == 0
//   thermo_ok  out  1         snapshot == (1 << count) - 1
//
// Optional feature (macro ENEMY_TALLY_AUTO_RESCAN_EN)
//   Adds a registered copy of alive, last_alive. In IDLE, any change of alive
//   starts a scan exactly as start=1 would. Without the macro, scans begin
//   only on start.
//
// Parameter constraint: 2**CNT_W > N_PLANES. With that constraint the
// accumulator cannot wrap.
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start (or for an alive change, with auto-rescan)
// SCAN    | one snapshot bit consumed per clock, idx 0 .. N_PLANES-1
// DONE    | result published, done high for this single cycle
//
module enemy_tally #(
  parameter int N_PLANES = 10,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_PLANES-1:0] alive,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                all_clear,
  output logic                thermo_ok
);

  localparam int IDX_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PLANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [N_PLANES-1:0]  snapshot, snapshot_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [CNT_W-1:0]     acc, acc_nxt;
  logic                 seen_zero, seen_zero_nxt;
  logic                 bad, bad_nxt;
  logic                 done_q, done_nxt;
  logic [CNT_W-1:0]     count_q, count_nxt;
  logic                 all_clear_q, all_clear_nxt;
  logic                 thermo_ok_q, thermo_ok_nxt;

  logic                 scan_req;
  logic                 cur_bit;
  logic [CNT_W-1:0]     acc_sum;
  logic                 bad_sum;

`ifdef ENEMY_TALLY_AUTO_RESCAN_EN
  logic [N_PLANES-1:0]  last_alive;

  // last_alive only tracks alive while idle. A change that happens during a
  // scan therefore still shows up as a difference once the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_alive <= '0;
    end else if (state == ST_IDLE) begin
      last_alive <= alive;
    end
  end

  assign scan_req = start | (alive != last_alive);
`else
  assign scan_req = start;
`endif

  // The bit consumed this cycle, plus the accumulator and shape flag that
  // include it. On the last bit these values are the final result, so they
  // are published straight from here instead of waiting one more cycle.
  assign cur_bit = snapshot[idx];
  assign acc_sum = acc + CNT_W'(cur_bit);
  assign bad_sum = bad | (cur_bit & seen_zero);

  always_comb begin
    state_nxt     = state;
    snapshot_nxt  = snapshot;
    idx_nxt       = idx;
    acc_nxt       = acc;
    seen_zero_nxt = seen_zero;
    bad_nxt       = bad;
    done_nxt      = 1'b0;
    count_nxt     = count_q;
    all_clear_nxt = all_clear_q;
    thermo_ok_nxt = thermo_ok_q;

    case (state)
      ST_IDLE: begin
        if (scan_req) begin
          snapshot_nxt  = alive;
          idx_nxt       = '0;
          acc_nxt       = '0;
          seen_zero_nxt = 1'b0;
          bad_nxt       = 1'b0;
          state_nxt     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        acc_nxt       = acc_sum;
        bad_nxt       = bad_sum;
        seen_zero_nxt = seen_zero | ~cur_bit;
        idx_nxt       = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
          count_nxt     = acc_sum;
          all_clear_nxt = (acc_sum == '0);
          thermo_ok_nxt = ~bad_sum;
          done_nxt      = 1'b1;
          state_nxt     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      snapshot    <= '0;
      idx         <= '0;
      acc         <= '0;
      seen_zero   <= 1'b0;
      bad         <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      all_clear_q <= 1'b1;
      thermo_ok_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      snapshot    <= snapshot_nxt;
      idx         <= idx_nxt;
      acc         <= acc_nxt;
      seen_zero   <= seen_zero_nxt;
      bad         <= bad_nxt;
      done_q      <= done_nxt;
      count_q     <= count_nxt;
      all_clear_q <= all_clear_nxt;
      thermo_ok_q <= thermo_ok_nxt;
    end
  end

  assign busy      = (state == ST_SCAN);
  assign done      = done_q;
  assign count     = count_q;
  assign all_clear = all_clear_q;
  assign thermo_ok = thermo_ok_q;

endmodule
